// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes symbolic instructions and loads them into instruction memory
// Holds the CPU while loading; a halt or a full memory ends the load.
module instr_encoder_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_mn,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_sa,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          overflow,
  output logic [AW:0]   count
);

  localparam logic [31:0]   HALT_WORD = 32'hFC00_0000;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic [AW-1:0] addr;
  logic [31:0] word;
  logic [31:0] enc_word;
  logic        begin_load;
  logic        accept;
  logic        force_halt;

  always_comb begin
    enc_word = HALT_WORD;
    case (in_mn)
      4'd0:  enc_word = {6'b000000, in_rs, in_rt, in_rd, in_sa, 6'b100000};
      4'd1:  enc_word = {6'b000000, in_rs, in_rt, in_rd, in_sa, 6'b100010};
      4'd2:  enc_word = {6'b000000, in_rs, in_rt, in_rd, in_sa, 6'b100100};
      4'd3:  enc_word = {6'b000000, in_rs, in_rt, in_rd, in_sa, 6'b100101};
      4'd4:  enc_word = {6'b000000, 5'd0,  in_rt, in_rd, in_sa, 6'b000000};
      4'd5:  enc_word = {6'b001000, in_rs, in_rt, in_imm};
      4'd6:  enc_word = {6'b001100, in_rs, in_rt, in_imm};
      4'd7:  enc_word = {6'b001101, in_rs, in_rt, in_imm};
      4'd8:  enc_word = {6'b001010, in_rs, in_rt, in_imm};
      4'd9:  enc_word = {6'b101011, in_rs, in_rt, in_imm};
      4'd10: enc_word = {6'b100011, in_rs, in_rt, in_imm};
      4'd11: enc_word = {6'b000100, in_rs, in_rt, in_imm};
      4'd12: enc_word = {6'b000101, in_rs, in_rt, in_imm};
      4'd13: enc_word = {6'b000001, in_rs, 5'd0,  in_imm};
      4'd14: enc_word = {6'b000010, in_target};
      default: enc_word = HALT_WORD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    imem_we   = 1'b0;
    cpu_hold  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACCEPT;
      end
      ACCEPT: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid) state_nxt = WRITE;
      end
      WRITE: begin
        imem_we  = 1'b1;
        cpu_hold = 1'b1;
        state_nxt = (word == HALT_WORD || addr == LAST_ADDR) ? DONE : ACCEPT;
      end
      DONE: begin
        done      = 1'b1;
        cpu_hold  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign begin_load = (state == IDLE) && start;
  assign accept     = (state == ACCEPT) && in_valid;
  // The last slot must always hold a halt so the CPU never runs off the end.
  assign force_halt = (addr == LAST_ADDR) && (in_mn != 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      word     <= '0;
    end else begin
      if (begin_load) begin
        addr     <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end
      if (accept) begin
        word <= force_halt ? HALT_WORD : enc_word;
        if (force_halt) overflow <= 1'b1;
      end
      if (state == WRITE) begin
        addr  <= addr + 1'b1;
        count <= count + 1'b1;
      end
    end
  end

  assign imem_addr  = addr;
  assign imem_wdata = word;

endmodule
